// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with prescaler, wrap/saturate and status flags
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_dn_i,
  input  logic             clear_ovf_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] out_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             cmp_match_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);
  logic [WIDTH-1:0] cnt_q, cnt_d, nxt_up, nxt_dn, lv;
  logic [PW-1:0] psc_q, psc_d;
  logic ovf_q, ovf_d, tick, step;
  always_comb begin
    tick   = en_i && !load_i;
    step   = tick && psc_q == PLAST;
    tc_o   = up_dn_i ? cnt_q == MAX : cnt_q == '0;
    nxt_up = cnt_q == MAX ? (SATURATE != 0 ? MAX : '0) : cnt_q + 1'b1;
    nxt_dn = cnt_q == '0 ? (SATURATE != 0 ? '0 : MAX) : cnt_q - 1'b1;
    lv     = load_val_i > MAX ? MAX : load_val_i;
    cnt_d  = load_i ? lv : step ? (up_dn_i ? nxt_up : nxt_dn) : cnt_q;
    psc_d  = load_i ? '0 : !tick ? psc_q : step ? '0 : psc_q + 1'b1;
    // a step taken at a range end sets ovf even when clear is requested
    ovf_d  = (step && tc_o) || (ovf_q && !clear_ovf_i);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      psc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      psc_q <= psc_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_o       = cnt_q;
  assign ovf_o       = ovf_q;
  assign cmp_match_o = cnt_q == cmp_val_i;
endmodule
